// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 4-stage IEEE-754 multiplier, FTZ, RNE/RTZ rounding, flags, global-stall valid/ready
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clkn_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic                   rnd_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [EXP_W+MAN_W:0]   res_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic [3:0]             flags_o
);
  localparam int EW = EXP_W + 2;
  localparam int PW = 2*MAN_W + 2;
  localparam int MW = TAG_W + 5;
  localparam int SB = EXP_W + MAN_W;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [EXP_W-1:0] EMAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [1:0] C_NUM = 2'd0, C_ZERO = 2'd1, C_INF = 2'd2, C_NAN = 2'd3;
  logic en;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic signed [EW-1:0] e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
  logic [MAN_W:0] ma1_q, ma1_d, mb1_q, mb1_d;
  logic [PW-1:0] p2_q, p2_d;
  logic [MAN_W-1:0] f3_q, f3_d;
  logic x3_q, x3_d;
  // sideband travelling with each op: {invalid, class, sign, rnd, tag}
  logic [MW-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic [SB:0] res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0] flg_q, flg_d;
  assign en = ~v4_q | out_ready_i;
  assign in_ready_o = en;
  assign out_valid_o = v4_q;
  assign res_o = res_q;
  assign tag_o = tag_q;
  assign flags_o = flg_q;
  logic [EXP_W-1:0] ea, eb;
  logic [1:0] ca, cb;
  logic nan1, inv1;
  always_comb begin
    ea = a_i[SB-1:MAN_W];
    eb = b_i[SB-1:MAN_W];
    ca = ea == '0 ? C_ZERO : ea != EONES ? C_NUM : |a_i[MAN_W-1:0] ? C_NAN : C_INF;
    cb = eb == '0 ? C_ZERO : eb != EONES ? C_NUM : |b_i[MAN_W-1:0] ? C_NAN : C_INF;
    inv1 = (ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF);
    nan1 = inv1 || ca == C_NAN || cb == C_NAN;
    v1_d = in_valid_i;
    e1_d = $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS;
    ma1_d = {1'b1, a_i[MAN_W-1:0]};
    mb1_d = {1'b1, b_i[MAN_W-1:0]};
    m1_d = {inv1,
            nan1 ? C_NAN : (ca == C_INF || cb == C_INF) ? C_INF :
            (ca == C_ZERO || cb == C_ZERO) ? C_ZERO : C_NUM,
            a_i[SB] ^ b_i[SB], rnd_i, tag_i};
  end
  always_comb begin
    v2_d = v1_q;
    e2_d = e1_q;
    m2_d = m1_q;
    p2_d = PW'(ma1_q) * PW'(mb1_q);
  end
  logic g3, s3, inc3, cy3;
  logic [MAN_W-1:0] fr3;
  always_comb begin
    fr3 = p2_q[PW-1] ? p2_q[PW-2:MAN_W+1] : p2_q[PW-3:MAN_W];
    g3 = p2_q[PW-1] ? p2_q[MAN_W] : p2_q[MAN_W-1];
    s3 = p2_q[PW-1] ? |p2_q[MAN_W-1:0] : |p2_q[MAN_W-2:0];
    inc3 = ~m2_q[TAG_W] & g3 & (s3 | fr3[0]);
    {cy3, f3_d} = {1'b0, fr3} + {{MAN_W{1'b0}}, inc3};
    e3_d = e2_q + $signed({{(EW-1){1'b0}}, p2_q[PW-1]}) + $signed({{(EW-1){1'b0}}, cy3});
    x3_d = g3 | s3;
    v3_d = v2_q;
    m3_d = m2_q;
  end
  logic inv4, sg4, rn4, of4, uf4;
  logic [1:0] c4;
  always_comb begin
    {inv4, c4, sg4, rn4, tag_d} = m3_q;
    of4 = e3_q >= EMAX;
    uf4 = e3_q[EW-1] | ~|e3_q;
    v4_d = v3_q;
    res_d = c4 == C_NAN  ? {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}} :
            c4 == C_INF  ? {sg4, EONES, {MAN_W{1'b0}}} :
            c4 == C_ZERO ? {sg4, {SB{1'b0}}} :
            of4 ? (rn4 ? {sg4, EMAXF, {MAN_W{1'b1}}} : {sg4, EONES, {MAN_W{1'b0}}}) :
            uf4 ? {sg4, {SB{1'b0}}} : {sg4, e3_q[EXP_W-1:0], f3_q};
    flg_d = c4 == C_NAN ? {inv4, 3'b000} : c4 != C_NUM ? 4'b0000 :
            of4 ? 4'b0101 : uf4 ? 4'b0011 : {3'b000, x3_q};
  end
  always_ff @(negedge clkn_i) begin
    if (rst_i) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      {e1_q, e2_q, e3_q} <= '0;
      {ma1_q, mb1_q, p2_q, f3_q, x3_q} <= '0;
      {m1_q, m2_q, m3_q} <= '0;
      res_q <= '0;
      tag_q <= '0;
      flg_q <= '0;
    end else if (en) begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      v4_q <= v4_d;
      e1_q <= e1_d;
      e2_q <= e2_d;
      e3_q <= e3_d;
      ma1_q <= ma1_d;
      mb1_q <= mb1_d;
      p2_q <= p2_d;
      f3_q <= f3_d;
      x3_q <= x3_d;
      m1_q <= m1_d;
      m2_q <= m2_d;
      m3_q <= m3_d;
      res_q <= res_d;
      tag_q <= tag_d;
      flg_q <= flg_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and randomized checks of fp_mul_pipe against an arithmetic reference model
module tb_fp_mul_pipe;
  logic clk = 1'b1, rst = 1'b1;
  logic in_valid = 0, in_ready, rnd = 0, out_valid, out_ready = 1;
  logic [31:0] a = 0, b = 0, res;
  logic [3:0] tag = 0, tag_o, flags;
  logic h_valid = 0, h_ready, h_ovalid;
  logic [15:0] ha = 0, hb = 0, hres;
  logic [3:0] h_tago, h_flags;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fp_mul_pipe u_dut (
    .clkn_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .tag_i(tag), .rnd_i(rnd), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .res_o(res), .tag_o(tag_o), .flags_o(flags)
  );
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_h (
    .clkn_i(clk), .rst_i(rst), .in_valid_i(h_valid), .in_ready_o(h_ready),
    .a_i(ha), .b_i(hb), .tag_i(4'd0), .rnd_i(1'b0), .out_valid_o(h_ovalid),
    .out_ready_i(1'b1), .res_o(hres), .tag_o(h_tago), .flags_o(h_flags)
  );
  // {a, b, rtz, expected result, expected flags}
  localparam logic [100:0] VEC [15] = '{
    {32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 4'b0000},
    {32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 4'b0001},
    {32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'b0001},
    {32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFE, 4'b0001},
    {32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 32'h407FFFFE, 4'b0001},
    {32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101},
    {32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101},
    {32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011},
    {32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000},
    {32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000},
    {32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000},
    {32'hFFC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},
    {32'hBF800000, 32'h40000000, 1'b1, 32'hC0000000, 4'b0000},
    {32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0001},
    {32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 4'b0001}
  };
  // Exact significand product, then rounding decided from the discarded remainder vs. half an ulp.
  function automatic void ref_mul(input longint x, input longint y, input bit rz,
                                  input int E, input int M, output longint r, output logic [3:0] f);
    longint ones, fm, bias, ex, ey, fx, fy, sb, p, e, q, rem, half;
    bit zx, zy, ix, iy, nx, ny, inv;
    int sh;
    ones = (longint'(1) << E) - 1;
    fm = (longint'(1) << M) - 1;
    bias = (longint'(1) << (E-1)) - 1;
    ex = (x >> M) & ones; ey = (y >> M) & ones;
    fx = x & fm; fy = y & fm;
    sb = (((x ^ y) >> (E+M)) & 1) << (E+M);
    zx = ex == 0; zy = ey == 0;
    ix = ex == ones && fx == 0; iy = ey == ones && fy == 0;
    nx = ex == ones && fx != 0; ny = ey == ones && fy != 0;
    inv = (ix && zy) || (zx && iy);
    f = 4'b0000;
    if (nx || ny || inv) begin
      r = (ones << M) | (longint'(1) << (M-1));
      f = {inv, 3'b000};
    end else if (ix || iy) r = sb | (ones << M);
    else if (zx || zy) r = sb;
    else begin
      p = (fx | (longint'(1) << M)) * (fy | (longint'(1) << M));
      sh = ((p >> (2*M+1)) != 0) ? M+1 : M;
      e = ex + ey - bias + longint'(sh - M);
      q = p >> sh;
      rem = p - (q << sh);
      half = longint'(1) << (sh-1);
      if (!rz && (rem > half || (rem == half && q[0]))) q = q + 1;
      if (q == (longint'(1) << (M+1))) begin q = q >> 1; e = e + 1; end
      if (e >= ones) begin
        r = rz ? (sb | ((ones-1) << M) | fm) : (sb | (ones << M));
        f = 4'b0101;
      end else if (e <= 0) begin
        r = sb;
        f = 4'b0011;
      end else begin
        r = sb | (e << M) | (q & fm);
        f = {3'b000, rem != 0};
      end
    end
  endfunction
  function automatic logic [31:0] rand_op();
    int k;
    logic [7:0] e;
    logic [22:0] m;
    k = $urandom_range(0, 15);
    e = k == 0 ? 8'd0 : k == 1 ? 8'd255 : k == 2 ? 8'($urandom_range(0, 255)) :
        k == 3 ? 8'($urandom_range(190, 254)) : k == 4 ? 8'($urandom_range(1, 64)) :
        8'($urandom_range(100, 154));
    m = k == 5 ? '1 : k == 6 ? '0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic rz, input logic [3:0] t,
                       output logic [31:0] r, output logic [3:0] f, output logic [3:0] to, output int lat);
    @(posedge clk);
    a = x; b = y; rnd = rz; tag = t; in_valid = 1; out_ready = 1;
    @(posedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
    end
    r = res; f = flags; to = tag_o;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h want 0", res); end
    checks++; if (tag_o !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag_o); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({h_ovalid, h_ready} !== 2'b01) begin errors++; $display("FAIL reset_fp16: got v=%b r=%b want v=0 r=1", h_ovalid, h_ready); end
    @(posedge clk);
    rst = 0;
  endtask
  task automatic test_directed();
    logic [100:0] v;
    logic [31:0] r;
    logic [3:0] f, t;
    int lat;
    for (int i = 0; i < 15; i++) begin
      v = VEC[i];
      do_op(v[100:69], v[68:37], v[36], 4'(i), r, f, t, lat);
      checks++; if (r !== v[35:4]) begin errors++; $display("FAIL dir%0d_res: %h x %h rtz=%b got %h want %h", i, v[100:69], v[68:37], v[36], r, v[35:4]); end
      checks++; if (f !== v[3:0]) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", i, f, v[3:0]); end
      checks++; if (t !== 4'(i)) begin errors++; $display("FAIL dir%0d_tag: got %h want %h", i, t, 4'(i)); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency: got %0d edges want 4", i, lat); end
    end
  endtask
  task automatic test_stream(input int n, input int pct);
    logic [39:0] exp_q[$];
    logic [39:0] held, want;
    longint r;
    logic [3:0] f;
    int sent = 0, got = 0, cyc = 0;
    bit acc = 1, hold = 0, extra = 0;
    in_valid = 0;
    while (got < n && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      if (acc || !in_valid) begin
        if (sent < n && $urandom_range(0, 9) < 8) begin
          a = rand_op(); b = rand_op(); rnd = 1'($urandom); tag = sent[3:0]; in_valid = 1;
        end else in_valid = 0;
      end
      out_ready = $urandom_range(0, 99) < pct;
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (hold) begin
        checks++;
        if ({out_valid, res, flags, tag_o} !== {1'b1, held}) begin
          errors++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, {res, flags, tag_o}, held);
        end
      end
      hold = out_valid && !out_ready;
      held = {res, flags, tag_o};
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected result %h", {res, flags, tag_o});
        end else begin
          want = exp_q.pop_front();
          if ({res, flags, tag_o} !== want) begin
            errors++; $display("FAIL stream_result#%0d: got %h want %h", got, {res, flags, tag_o}, want);
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        ref_mul(longint'(a), longint'(b), rnd, 8, 23, r, f);
        exp_q.push_back({32'(r), f, tag});
        sent++;
      end
    end
    in_valid = 0;
    out_ready = 1;
    checks++; if (got !== n) begin errors++; $display("FAIL stream_count: got %0d results want %0d", got, n); end
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) extra = 1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL stream_dup: got extra result want none"); end
  endtask
  task automatic test_reset_flight();
    logic [31:0] r;
    logic [3:0] f, t;
    int lat;
    bit stale = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      a = 32'h40000000 + 32'(i); b = 32'h3F800000; rnd = 0; tag = 4'(i + 1); in_valid = 1;
    end
    @(posedge clk);
    in_valid = 0; rst = 1;
    @(posedge clk);
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_reset_valid: got %b want 0", out_valid); end
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) stale = 1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL flight_stale: got a result after reset want none"); end
    do_op(32'h40000000, 32'h40400000, 1'b0, 4'hA, r, f, t, lat);
    checks++; if ({r, f, t} !== {32'h40C00000, 4'b0000, 4'hA}) begin errors++; $display("FAIL flight_after: got %h want %h", {r, f, t}, {32'h40C00000, 4'b0000, 4'hA}); end
  endtask
  task automatic test_fp16();
    longint r;
    logic [3:0] f;
    int lat;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      ha = i == 0 ? 16'h4000 : 16'($urandom);
      hb = i == 0 ? 16'h4200 : 16'($urandom);
      h_valid = 1;
      @(posedge clk);
      h_valid = 0;
      lat = 1;
      while (!h_ovalid && lat < 20) begin
        @(posedge clk);
        lat++;
      end
      ref_mul(longint'(ha), longint'(hb), 1'b0, 5, 10, r, f);
      if (i == 0) begin
        checks++; if (hres !== 16'h4600) begin errors++; $display("FAIL fp16_t1: got %h want 4600", hres); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL fp16_latency: got %0d want 4", lat); end
        checks++; if (h_tago !== 4'h0) begin errors++; $display("FAIL fp16_tag: got %h want 0", h_tago); end
      end
      checks++;
      if ({hres, h_flags} !== {16'(r), f}) begin
        errors++; $display("FAIL fp16_rand%0d: %h x %h got %h/%b want %h/%b", i, ha, hb, hres, h_flags, 16'(r), f);
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_stream(60, 100);
    test_stream(60, 40);
    test_stream(8, 50);
    test_reset_flight();
    test_fp16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
